// File: rtl/zafx32_pkg.sv
// Shared definitions for the ZAFx32 fetch/decode stage: instruction field
// positions, the default reset PC and the fetch controller state type.
package zafx32_pkg;

  localparam int OPCODE_W = 6;
  localparam int REG_W    = 5;
  localparam int IMM_W    = 16;
  localparam int TGT_W    = 26;
  localparam int FUNCT_W  = 6;

  localparam int OPCODE_LSB = 26;
  localparam int RS_LSB     = 21;
  localparam int RT_LSB     = 16;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_LSB    = 0;
  localparam int TGT_LSB    = 0;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    START    = 2'd0,
    FETCH    = 2'd1,
    BLOCKED  = 2'd2,
    REDIRECT = 2'd3
  } fd_state_t;

endpackage

// File: rtl/instr_queue.sv
// DEPTH-entry FIFO of {pc, instr} pairs feeding decode; clear wins over push/pop.
module instr_queue import zafx32_pkg::*; #(
  parameter int DEPTH = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_clear,
  input  logic [31:0]              i_pc,
  input  logic [31:0]              i_instr,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic [31:0]              o_head_pc,
  output logic [31:0]              o_head_instr
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [31:0]   r_pc    [DEPTH];
  logic [31:0]   r_instr [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;

  always_ff @(posedge i_clk) begin
    if (i_push && !i_clear) begin
      r_pc[r_wptr]    <= i_pc;
      r_instr[r_wptr] <= i_instr;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + PTR_ONE;
      if (i_pop)  r_rptr <= r_rptr + PTR_ONE;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_empty      = (r_count == '0);
  assign o_full       = (r_count == CNT_FULL);
  assign o_count      = r_count;
  assign o_head_pc    = r_pc[r_rptr];
  assign o_head_instr = r_instr[r_rptr];

endmodule

// File: rtl/fetch_decode_stage.sv
// ZAFx32 fetch + field-split stage: fetches words into a small queue and presents
// the head split into MIPS fields. Define IFD_PERF_CNT_EN to add fetch/bubble counters.
module fetch_decode_stage import zafx32_pkg::*; #(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic [31:0] i_flush_pc,
  output logic        o_instr_valid,
  output logic [31:0] o_pc_out,
  output logic [5:0]  o_opcode,
  output logic [4:0]  o_rs,
  output logic [4:0]  o_rt,
  output logic [4:0]  o_rd,
  output logic [4:0]  o_shamt,
  output logic [5:0]  o_funct,
  output logic [15:0] o_imm16,
  output logic [25:0] o_target26
`ifdef IFD_PERF_CNT_EN
  ,
  output logic [31:0] o_fetch_cnt,
  output logic [31:0] o_bubble_cnt
`endif
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam logic [AW:0] CNT_LAST = (AW+1)'(BUF_DEPTH - 1);

  fd_state_t   r_state;
  logic [31:0] r_pc;
  logic [31:0] r_addr;
  logic        r_req;

  logic        w_push;
  logic        w_pop;
  logic        w_fill;
  logic        w_empty;
  logic        w_full;
  logic [AW:0] w_count;
  logic [31:0] w_head_pc;
  logic [31:0] w_head_instr;
  logic [31:0] w_instr;
  logic [31:0] w_flush_tgt;
  logic [31:0] w_pc_next;

  assign w_flush_tgt = i_flush_pc & 32'hFFFF_FFFC;
  assign w_pc_next   = r_pc + 32'd4;
  assign w_pop       = !w_empty && !i_stall && !i_flush;
  assign w_push      = (r_state == FETCH) && i_imem_ack && !i_flush;
  assign w_fill      = w_push && !w_pop && (w_count == CNT_LAST);

  instr_queue #(.DEPTH(BUF_DEPTH)) u_queue (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_push       (w_push),
    .i_pop        (w_pop),
    .i_clear      (i_flush),
    .i_pc         (r_addr),
    .i_instr      (i_imem_rdata),
    .o_empty      (w_empty),
    .o_full       (w_full),
    .o_count      (w_count),
    .o_head_pc    (w_head_pc),
    .o_head_instr (w_head_instr)
  );

  // In REDIRECT r_pc holds the latched flush target while r_addr stays on the
  // abandoned request until its ack drains it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= START;
      r_pc    <= RESET_PC;
      r_req   <= 1'b0;
      r_addr  <= '0;
    end else if (i_flush) begin
      r_pc <= w_flush_tgt;
      if (r_req && !i_imem_ack) begin
        r_state <= REDIRECT;
      end else begin
        r_state <= FETCH;
        r_req   <= 1'b1;
        r_addr  <= w_flush_tgt;
      end
    end else begin
      case (r_state)
        START: begin
          r_state <= FETCH;
          r_req   <= 1'b1;
          r_addr  <= r_pc;
        end
        FETCH: begin
          if (i_imem_ack) begin
            r_pc <= w_pc_next;
            if (w_fill) begin
              r_state <= BLOCKED;
              r_req   <= 1'b0;
            end else begin
              r_addr <= w_pc_next;
            end
          end
        end
        BLOCKED: begin
          if (w_pop || !w_full) begin
            r_state <= FETCH;
            r_req   <= 1'b1;
            r_addr  <= r_pc;
          end
        end
        REDIRECT: begin
          if (i_imem_ack) begin
            r_state <= FETCH;
            r_addr  <= r_pc;
          end
        end
        default: r_state <= START;
      endcase
    end
  end

  assign o_imem_req    = r_req;
  assign o_imem_addr   = r_addr;
  assign o_instr_valid = !w_empty;
  assign o_pc_out      = w_empty ? '0 : w_head_pc;
  assign w_instr       = w_empty ? '0 : w_head_instr;

  assign o_opcode   = w_instr[OPCODE_LSB +: OPCODE_W];
  assign o_rs       = w_instr[RS_LSB     +: REG_W];
  assign o_rt       = w_instr[RT_LSB     +: REG_W];
  assign o_rd       = w_instr[RD_LSB     +: REG_W];
  assign o_shamt    = w_instr[SHAMT_LSB  +: REG_W];
  assign o_funct    = w_instr[FUNCT_LSB  +: FUNCT_W];
  assign o_imm16    = w_instr[IMM_LSB    +: IMM_W];
  assign o_target26 = w_instr[TGT_LSB    +: TGT_W];

`ifdef IFD_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_bubble_cnt;

  // Counters survive flush; only reset clears them.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fetch_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (w_pop) r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if ((r_state != START) && w_empty) r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end
  end

  assign o_fetch_cnt  = r_fetch_cnt;
  assign o_bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Scoreboard bench for fetch_decode_stage: directed fetch/stall/flush/reset vectors,
// plus a second instance with RESET_PC near the top of memory for address wrap.
module tb_fetch_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ack, stall, flush;
  logic [31:0] rdata, flush_pc;

  logic        req, valid;
  logic [31:0] addr, pc_out;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm16;
  logic [25:0] target26;

  logic        r5_req, r5_valid;
  logic [31:0] r5_addr, r5_pc_out;
  logic [5:0]  r5_opcode, r5_funct;
  logic [4:0]  r5_rs, r5_rt, r5_rd, r5_shamt;
  logic [15:0] r5_imm16;
  logic [25:0] r5_target26;
`ifdef IFD_PERF_CNT_EN
  logic [31:0] fetch_cnt, bubble_cnt, r5_fetch_cnt, r5_bubble_cnt;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  fetch_decode_stage #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .o_imem_req(req), .o_imem_addr(addr),
    .i_imem_ack(ack), .i_imem_rdata(rdata),
    .i_stall(stall), .i_flush(flush), .i_flush_pc(flush_pc),
    .o_instr_valid(valid), .o_pc_out(pc_out),
    .o_opcode(opcode), .o_rs(rs), .o_rt(rt), .o_rd(rd), .o_shamt(shamt),
    .o_funct(funct), .o_imm16(imm16), .o_target26(target26)
`ifdef IFD_PERF_CNT_EN
    , .o_fetch_cnt(fetch_cnt), .o_bubble_cnt(bubble_cnt)
`endif
  );

  fetch_decode_stage #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(2)) u_dut_wrap (
    .i_clk(clk), .i_rst_n(rst_n),
    .o_imem_req(r5_req), .o_imem_addr(r5_addr),
    .i_imem_ack(1'b1), .i_imem_rdata(32'h0000_0000),
    .i_stall(1'b0), .i_flush(1'b0), .i_flush_pc(32'h0000_0000),
    .o_instr_valid(r5_valid), .o_pc_out(r5_pc_out),
    .o_opcode(r5_opcode), .o_rs(r5_rs), .o_rt(r5_rt), .o_rd(r5_rd), .o_shamt(r5_shamt),
    .o_funct(r5_funct), .o_imm16(r5_imm16), .o_target26(r5_target26)
`ifdef IFD_PERF_CNT_EN
    , .o_fetch_cnt(r5_fetch_cnt), .o_bubble_cnt(r5_bubble_cnt)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of inputs, record an accepted fetch, check the request at negedge.
  task automatic cyc(input logic a, input logic [31:0] rd_w, input logic stl, input logic fl,
                     input logic [31:0] fpc, input logic exp_req, input logic [31:0] exp_addr,
                     input logic acc);
    ack = a; rdata = rd_w; stall = stl; flush = fl; flush_pc = fpc;
    if (acc) sb.push_back('{pc: exp_addr, ins: rd_w});
    @(negedge clk);
    chk("imem_req", 32'(req), 32'(exp_req));
    if (exp_req) chk("imem_addr", addr, exp_addr);
  endtask

  task automatic do_reset();
    ack = 1'b0; stall = 1'b0; flush = 1'b0; rdata = '0; flush_pc = '0;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_addr", addr, 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_pc_out", pc_out, 32'd0);
    chk("rst_fields", {opcode, rs, rt, rd, shamt, funct}, 32'd0);
    chk("rst_imm_tgt", {imm16 | target26[15:0], target26[25:16], 6'd0}, 32'd0);
`ifdef IFD_PERF_CNT_EN
    chk("rst_fetch_cnt", fetch_cnt, 32'd0);
    chk("rst_bubble_cnt", bubble_cnt, 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: every pop the DUT performs must match the next expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && valid && !stall && !flush) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL pop_unexpected: got pc=%h opcode=%h, expected no instruction", pc_out, opcode);
        end else begin
          e = sb.pop_front();
          chk("pop_pc", pc_out, e.pc);
          chk("pop_opcode", 32'(opcode), 32'(e.ins[31:26]));
          chk("pop_rs", 32'(rs), 32'(e.ins[25:21]));
          chk("pop_rt", 32'(rt), 32'(e.ins[20:16]));
          chk("pop_rd", 32'(rd), 32'(e.ins[15:11]));
          chk("pop_shamt", 32'(shamt), 32'(e.ins[10:6]));
          chk("pop_funct", 32'(funct), 32'(e.ins[5:0]));
          chk("pop_imm16", 32'(imm16), 32'(e.ins[15:0]));
          chk("pop_target26", 32'(target26), 32'(e.ins[25:0]));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ack = 1'b0; stall = 1'b0; flush = 1'b0; rdata = '0; flush_pc = '0;
    #3;
    do_reset();

    // Streaming fetch, no stall; wrap instance runs in lockstep
    cyc(0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 0);
    tick();
    cyc(1, 32'h2009_0005, 0, 0, 32'h0, 1, 32'h0, 1);
    chk("t1_valid_latency", 32'(valid), 32'd0);
    chk("t5_req", 32'(r5_req), 32'd1);
    chk("t5_addr0", r5_addr, 32'hFFFF_FFF8);
    tick();
    cyc(1, 32'h2009_0005, 0, 0, 32'h0, 1, 32'h4, 1);
    chk("t1_valid", 32'(valid), 32'd1);
    chk("t1_opcode", 32'(opcode), 32'h08);
    chk("t1_rs", 32'(rs), 32'd0);
    chk("t1_rt", 32'(rt), 32'd9);
    chk("t1_imm16", 32'(imm16), 32'h0005);
    chk("t5_addr1", r5_addr, 32'hFFFF_FFFC);
    chk("t5_pc_out", r5_pc_out, 32'hFFFF_FFF8);
    tick();
    cyc(1, 32'h2009_0005, 0, 0, 32'h0, 1, 32'h8, 1);
    chk("t5_addr_wrap", r5_addr, 32'h0000_0000);
    tick();
    cyc(0, 32'h0, 0, 0, 32'h0, 1, 32'hC, 0);
    tick();
    cyc(0, 32'h0, 0, 0, 32'h0, 1, 32'hC, 0);
    chk("t1_drained", 32'(valid), 32'd0);
`ifdef IFD_PERF_CNT_EN
    chk("t1_fetch_cnt", fetch_cnt, 32'd3);
    chk("t1_bubble_cnt", bubble_cnt, 32'd1);
`endif
    tick();

    // Stall: queue fills, BLOCKED ignores acks, resume at 8 after first pop
    do_reset();
    cyc(0, 32'h0, 1, 0, 32'h0, 0, 32'h0, 0);
    tick();
    cyc(1, 32'h0000_0020, 1, 0, 32'h0, 1, 32'h0, 1);
    tick();
    cyc(1, 32'h1111_2222, 1, 0, 32'h0, 1, 32'h4, 1);
    chk("t2_pc_out", pc_out, 32'h0);
    tick();
    for (int i = 0; i < 3; i++) begin
      cyc(1, 32'hFFFF_FFFF, 1, 0, 32'h0, 0, 32'h0, 0);
      chk("t2_blocked_pc_out", pc_out, 32'h0);
      chk("t2_blocked_valid", 32'(valid), 32'd1);
      tick();
    end
    cyc(0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 0);
    tick();
    cyc(1, 32'h3C01_ABCD, 0, 0, 32'h0, 1, 32'h8, 1);
    chk("t2_second_pc", pc_out, 32'h4);
    tick();
    cyc(0, 32'h0, 0, 0, 32'h0, 1, 32'hC, 0);
    tick();
    cyc(0, 32'h0, 0, 0, 32'h0, 1, 32'hC, 0);
    chk("t2_drained", 32'(valid), 32'd0);
    tick();

    // Reset asserted while BLOCKED with a full queue
    do_reset();
    cyc(0, 32'h0, 1, 0, 32'h0, 0, 32'h0, 0);
    tick();
    cyc(1, 32'hAAAA_0001, 1, 0, 32'h0, 1, 32'h0, 1);
    tick();
    cyc(1, 32'hAAAA_0002, 1, 0, 32'h0, 1, 32'h4, 1);
    tick();
    cyc(0, 32'h0, 1, 0, 32'h0, 0, 32'h0, 0);
    chk("t6_full_valid", 32'(valid), 32'd1);
    tick();
    do_reset();
    cyc(0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 0);
    tick();
    cyc(0, 32'h0, 0, 0, 32'h0, 1, 32'h0, 0);
    chk("t6_valid_after", 32'(valid), 32'd0);
    tick();

    // Flush with an outstanding request -> REDIRECT, address held, data dropped
    do_reset();
    cyc(0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 0);
    tick();
    cyc(1, 32'h0123_4567, 1, 0, 32'h0, 1, 32'h0, 1);
    tick();
    sb.delete();
    cyc(0, 32'h0, 1, 1, 32'h0000_0102, 1, 32'h4, 0);
    tick();
    cyc(0, 32'h0, 0, 0, 32'h0, 1, 32'h4, 0);
    chk("t3_valid_r1", 32'(valid), 32'd0);
    tick();
    cyc(0, 32'h0, 0, 0, 32'h0, 1, 32'h4, 0);
    chk("t3_valid_r2", 32'(valid), 32'd0);
    tick();
    cyc(1, 32'hDEAD_BEEF, 0, 0, 32'h0, 1, 32'h4, 0);
    chk("t3_valid_r3", 32'(valid), 32'd0);
    tick();
    cyc(1, 32'h8C43_0010, 0, 0, 32'h0, 1, 32'h100, 1);
    chk("t3_valid_tgt", 32'(valid), 32'd0);
    tick();
    cyc(0, 32'h0, 0, 0, 32'h0, 1, 32'h104, 0);
    chk("t3_pc_out", pc_out, 32'h100);
    tick();

    // Flush together with ack, then back-to-back flushes in REDIRECT
    cyc(1, 32'hBAD0_0001, 0, 1, 32'h0000_2000, 1, 32'h104, 0);
    tick();
    cyc(0, 32'h0, 0, 0, 32'h0, 1, 32'h2000, 0);
    chk("t4_no_acked_word", 32'(valid), 32'd0);
    tick();
    cyc(0, 32'h0, 0, 1, 32'h0000_0300, 1, 32'h2000, 0);
    tick();
    cyc(0, 32'h0, 0, 1, 32'h0000_0407, 1, 32'h2000, 0);
    tick();
    cyc(1, 32'hBAD0_0002, 0, 0, 32'h0, 1, 32'h2000, 0);
    chk("t4_valid_redirect", 32'(valid), 32'd0);
    tick();
    cyc(1, 32'h0211_8020, 0, 0, 32'h0, 1, 32'h404, 1);
    tick();
    cyc(0, 32'h0, 0, 0, 32'h0, 1, 32'h408, 0);
    chk("t4_pc_out", pc_out, 32'h404);
    chk("t4_rt", 32'(rt), 32'd17);
    chk("t4_rd", 32'(rd), 32'd16);
    chk("t4_funct", 32'(funct), 32'h20);
    tick();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
